// File: rtl/cv32e40p_x_if_pkg.sv
// cv32e40p_x_if_pkg: shared types and helpers for the X-interface accelerator fan-out
package cv32e40p_x_if_pkg;
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        dualwb;
        logic        error;
    } x_acc_resp_t;
    typedef enum logic {IDLE, COLLECT} x_dispatch_state_e;
    function automatic int unsigned acc_id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/cv32e40p_x_if_rr_arb.sv
// cv32e40p_x_if_rr_arb: round-robin arbiter, priority restarts just after the last granted slot
module cv32e40p_x_if_rr_arb
    import cv32e40p_x_if_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = acc_id_width(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);
    logic [IW-1:0] ptr;
    logic [IW-1:0] c;
    logic          found;
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        c     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            c = IW'((32'(ptr) + k) % N);
            if (!found && req[c]) begin
                found    = 1'b1;
                grant[c] = 1'b1;
                idx      = c;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (advance)
            ptr <= (32'(idx) == N - 1) ? '0 : idx + 1'b1;
    end
endmodule

// File: rtl/cv32e40p_x_if_dispatch.sv
// cv32e40p_x_if_dispatch: broadcasts X-interface offloads to NUM_ACC accelerators, merges their
// accept decisions and round-robins their results back to the core.
module cv32e40p_x_if_dispatch
    import cv32e40p_x_if_pkg::*;
#(
    parameter int unsigned NUM_ACC         = 2,
    parameter int unsigned NUM_RS          = 3,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned ID_W            = acc_id_width(NUM_ACC)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         x_q_valid_i,
    output logic                         x_q_ready_o,
    input  logic [31:0]                  x_q_instr_data_i,
    input  logic [NUM_RS*DATA_WIDTH-1:0] x_q_rs_i,
    input  logic [NUM_RS-1:0]            x_q_rs_valid_i,
    input  logic                         x_q_rd_clean_i,
    output logic                         x_k_accept_o,
    output logic                         x_k_is_mem_op_o,
    output logic                         x_k_writeback_o,
    output logic                         x_p_valid_o,
    input  logic                         x_p_ready_i,
    output logic [4:0]                   x_p_rd_o,
    output logic [DATA_WIDTH-1:0]        x_p_data_o,
    output logic                         x_p_dualwb_o,
    output logic                         x_p_error_o,
    output logic [ID_W-1:0]              x_p_acc_id_o,
    output logic [NUM_ACC-1:0]           acc_q_valid_o,
    input  logic [NUM_ACC-1:0]           acc_q_ready_i,
    output logic [31:0]                  acc_q_instr_data_o,
    output logic [NUM_RS*DATA_WIDTH-1:0] acc_q_rs_o,
    output logic [NUM_RS-1:0]            acc_q_rs_valid_o,
    output logic                         acc_q_rd_clean_o,
    input  logic [NUM_ACC-1:0]           acc_k_accept_i,
    input  logic [NUM_ACC-1:0]           acc_k_is_mem_op_i,
    input  logic [NUM_ACC-1:0]           acc_k_writeback_i,
    input  logic [NUM_ACC-1:0]           acc_p_valid_i,
    output logic [NUM_ACC-1:0]           acc_p_ready_o,
    input  logic [NUM_ACC*5-1:0]         acc_p_rd_i,
    input  logic [NUM_ACC*DATA_WIDTH-1:0] acc_p_data_i,
    input  logic [NUM_ACC-1:0]           acc_p_dualwb_i,
    input  logic [NUM_ACC-1:0]           acc_p_error_i,
    output logic                         multi_accept_err_o,
    output logic                         resp_err_o
);
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned TW = CW + ID_W;
    x_dispatch_state_e          state;
    logic [NUM_ACC-1:0]         done, lat_acc, lat_mem, lat_wb, hs;
    logic [NUM_ACC-1:0]         eff_acc, eff_mem, eff_wb, inc, dec, zero, grant;
    logic [CW-1:0]              cnt [NUM_ACC];
    logic [TW-1:0]              total;
    logic [ID_W-1:0]            win, idx;
    logic                       stall, can_load, load;
    logic [4:0]                 sel_rd;
    logic [DATA_WIDTH-1:0]      sel_data;
    logic                       sel_dw, sel_err;
    assign acc_q_instr_data_o = x_q_instr_data_i;
    assign acc_q_rs_o         = x_q_rs_i;
    assign acc_q_rs_valid_o   = x_q_rs_valid_i;
    assign acc_q_rd_clean_o   = x_q_rd_clean_i;
    always_comb begin
        total = '0;
        for (int i = 0; i < NUM_ACC; i++) begin
            total   = total + TW'(cnt[i]);
            zero[i] = (cnt[i] == '0);
        end
    end
    // Stall only gates a fresh request; one already being collected runs to completion
    assign stall         = (state == IDLE) && (total >= TW'(MAX_OUTSTANDING));
    assign acc_q_valid_o = {NUM_ACC{x_q_valid_i & ~stall & ~rst_i}} & ~done;
    assign hs            = acc_q_valid_o & acc_q_ready_i;
    assign x_q_ready_o   = x_q_valid_i & ~rst_i & (&(done | hs));
    assign eff_acc       = (hs & acc_k_accept_i) | (done & lat_acc);
    assign eff_mem       = (hs & acc_k_is_mem_op_i) | (done & lat_mem);
    assign eff_wb        = (hs & acc_k_writeback_i) | (done & lat_wb);
    always_comb begin
        win = '0;
        for (int i = int'(NUM_ACC) - 1; i >= 0; i--)
            if (eff_acc[i]) win = ID_W'(i);
    end
    assign x_k_accept_o    = x_q_ready_o & (|eff_acc);
    assign x_k_is_mem_op_o = x_k_accept_o & eff_mem[win];
    assign x_k_writeback_o = x_k_accept_o & eff_wb[win];
    always_comb begin
        inc      = '0;
        inc[win] = x_k_writeback_o;
    end
    cv32e40p_x_if_rr_arb #(.N(NUM_ACC), .IW(ID_W)) u_arb (
        .clk     (clk_i),
        .rst     (rst_i),
        .req     (acc_p_valid_i),
        .advance (load),
        .grant   (grant),
        .idx     (idx)
    );
    assign can_load      = ~rst_i & (~x_p_valid_o | x_p_ready_i);
    assign acc_p_ready_o = grant & {NUM_ACC{can_load}};
    assign dec           = acc_p_ready_o & acc_p_valid_i;
    assign load          = |dec;
    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        sel_dw   = 1'b0;
        sel_err  = 1'b0;
        for (int i = 0; i < NUM_ACC; i++) begin
            if (grant[i]) begin
                sel_rd   = acc_p_rd_i[i*5 +: 5];
                sel_data = acc_p_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                sel_dw   = acc_p_dualwb_i[i];
                sel_err  = acc_p_error_i[i];
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state              <= IDLE;
            done               <= '0;
            lat_acc            <= '0;
            lat_mem            <= '0;
            lat_wb             <= '0;
            x_p_valid_o        <= 1'b0;
            x_p_rd_o           <= '0;
            x_p_data_o         <= '0;
            x_p_dualwb_o       <= 1'b0;
            x_p_error_o        <= 1'b0;
            x_p_acc_id_o       <= '0;
            multi_accept_err_o <= 1'b0;
            resp_err_o         <= 1'b0;
        end else begin
            done    <= x_q_ready_o ? '0 : (done | hs);
            state   <= (!x_q_ready_o && |(done | hs)) ? COLLECT : IDLE;
            lat_acc <= (lat_acc & ~hs) | (acc_k_accept_i & hs);
            lat_mem <= (lat_mem & ~hs) | (acc_k_is_mem_op_i & hs);
            lat_wb  <= (lat_wb & ~hs) | (acc_k_writeback_i & hs);
            if (x_q_ready_o && $countones(eff_acc) > 1) multi_accept_err_o <= 1'b1;
            if (|(dec & zero)) resp_err_o <= 1'b1;
            x_p_valid_o <= load | (x_p_valid_o & ~x_p_ready_i);
            if (load) begin
                x_p_rd_o     <= sel_rd;
                x_p_data_o   <= sel_data;
                x_p_dualwb_o <= sel_dw;
                x_p_error_o  <= sel_err;
                x_p_acc_id_o <= idx;
            end
        end
    end
    // A response against an empty counter is still forwarded; the counter just floors at zero
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_ACC; i++) begin
            if (rst_i)
                cnt[i] <= '0;
            else if (inc[i] && !dec[i])
                cnt[i] <= cnt[i] + 1'b1;
            else if (dec[i] && !inc[i] && !zero[i])
                cnt[i] <= cnt[i] - 1'b1;
        end
    end
endmodule

// File: tb/tb_cv32e40p_x_if_dispatch.sv
// tb_cv32e40p_x_if_dispatch: scoreboard bench for the two-accelerator X-interface dispatcher
module tb_cv32e40p_x_if_dispatch;
    localparam int NA = 2, NRS = 3, DW = 32, MO = 4;
    logic clk = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk = ~clk;
    logic              x_q_valid_i, x_q_ready_o, x_q_rd_clean_i;
    logic [31:0]       x_q_instr_data_i;
    logic [NRS*DW-1:0] x_q_rs_i;
    logic [NRS-1:0]    x_q_rs_valid_i;
    logic              x_k_accept_o, x_k_is_mem_op_o, x_k_writeback_o;
    logic              x_p_valid_o, x_p_ready_i, x_p_dualwb_o, x_p_error_o;
    logic [4:0]        x_p_rd_o;
    logic [DW-1:0]     x_p_data_o;
    logic [0:0]        x_p_acc_id_o;
    logic [NA-1:0]     acc_q_valid_o, acc_q_ready_i;
    logic [31:0]       acc_q_instr_data_o;
    logic [NRS*DW-1:0] acc_q_rs_o;
    logic [NRS-1:0]    acc_q_rs_valid_o;
    logic              acc_q_rd_clean_o;
    logic [NA-1:0]     acc_k_accept_i, acc_k_is_mem_op_i, acc_k_writeback_i;
    logic [NA-1:0]     acc_p_valid_i, acc_p_ready_o, acc_p_dualwb_i, acc_p_error_i;
    logic [NA*5-1:0]   acc_p_rd_i;
    logic [NA*DW-1:0]  acc_p_data_i;
    logic              multi_accept_err_o, resp_err_o;

    cv32e40p_x_if_dispatch #(.NUM_ACC(NA), .NUM_RS(NRS), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .x_q_valid_i(x_q_valid_i), .x_q_ready_o(x_q_ready_o), .x_q_instr_data_i(x_q_instr_data_i),
        .x_q_rs_i(x_q_rs_i), .x_q_rs_valid_i(x_q_rs_valid_i), .x_q_rd_clean_i(x_q_rd_clean_i),
        .x_k_accept_o(x_k_accept_o), .x_k_is_mem_op_o(x_k_is_mem_op_o), .x_k_writeback_o(x_k_writeback_o),
        .x_p_valid_o(x_p_valid_o), .x_p_ready_i(x_p_ready_i), .x_p_rd_o(x_p_rd_o), .x_p_data_o(x_p_data_o),
        .x_p_dualwb_o(x_p_dualwb_o), .x_p_error_o(x_p_error_o), .x_p_acc_id_o(x_p_acc_id_o),
        .acc_q_valid_o(acc_q_valid_o), .acc_q_ready_i(acc_q_ready_i),
        .acc_q_instr_data_o(acc_q_instr_data_o), .acc_q_rs_o(acc_q_rs_o),
        .acc_q_rs_valid_o(acc_q_rs_valid_o), .acc_q_rd_clean_o(acc_q_rd_clean_o),
        .acc_k_accept_i(acc_k_accept_i), .acc_k_is_mem_op_i(acc_k_is_mem_op_i),
        .acc_k_writeback_i(acc_k_writeback_i),
        .acc_p_valid_i(acc_p_valid_i), .acc_p_ready_o(acc_p_ready_o), .acc_p_rd_i(acc_p_rd_i),
        .acc_p_data_i(acc_p_data_i), .acc_p_dualwb_i(acc_p_dualwb_i), .acc_p_error_i(acc_p_error_i),
        .multi_accept_err_o(multi_accept_err_o), .resp_err_o(resp_err_o)
    );

    int          pass_cnt = 0, chk_cnt = 0;
    logic [2:0]  exp_k[$];
    logic [39:0] exp_p[$];
    int          cnt_m[NA];
    logic        multi_m, err_m;
    int          cyc, c;
    int          ka[NA];
    logic [1:0]  qv, rdy;
    logic [39:0] pr, d1;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", n, act, exp);
    endtask

    task automatic fail(input string n, input string what);
        chk_cnt++;
        $display("FAIL %s: %s", n, what);
    endtask

    function automatic logic [39:0] pk(input int id, input logic [4:0] rd, input logic [31:0] d,
                                       input logic dw, input logic er);
        return {1'(id), rd, d, dw, er};
    endfunction

    always @(negedge clk) begin
        if (!rst_i) begin
            if (x_q_ready_o) begin
                if (exp_k.size() == 0) fail("k_unexpected", "got a core handshake, expected none");
                else chk("k_decision", {61'd0, x_k_accept_o, x_k_is_mem_op_o, x_k_writeback_o}, {61'd0, exp_k.pop_front()});
            end
            if (x_p_valid_o && x_p_ready_i) begin
                if (exp_p.size() == 0) fail("p_unexpected", "got a response, expected none");
                else chk("p_response", {24'd0, x_p_acc_id_o, x_p_rd_o, x_p_data_o, x_p_dualwb_o, x_p_error_o},
                         {24'd0, exp_p.pop_front()});
            end
        end
    end

    // Reference: OR of accepts, lowest-index acceptor supplies mem/wb; wb acceptances count as outstanding
    task automatic issue(input int d0, input int d1, input logic [1:0] a, input logic [1:0] m,
                         input logic [1:0] w, output int cy, output logic [1:0] q1);
        int win;
        logic ac;
        win = a[0] ? 0 : 1;
        ac  = |a;
        exp_k.push_back({ac, ac & m[win], ac & w[win]});
        if (a == 2'b11) multi_m = 1'b1;
        if (ac && w[win]) cnt_m[win]++;
        x_q_valid_i = 1'b1;
        x_q_instr_data_i = $urandom;
        x_q_rs_i = {$urandom, $urandom, $urandom};
        x_q_rs_valid_i = 3'($urandom);
        x_q_rd_clean_i = 1'($urandom);
        acc_k_accept_i = a;
        acc_k_is_mem_op_i = m;
        acc_k_writeback_i = w;
        cy = -1;
        q1 = 2'b00;
        for (int t = 0; t < 30; t++) begin
            acc_q_ready_i = {t >= d1, t >= d0};
            @(negedge clk);
            if (t == 1) q1 = acc_q_valid_o;
            if (x_q_ready_o) cy = t;
            @(posedge clk); #1;
            if (cy >= 0) break;
        end
        x_q_valid_i = 1'b0;
        acc_q_ready_i = '0;
        if (cy < 0) fail("req_timeout", "got no core handshake in 30 cycles, expected one");
    endtask

    task automatic send_resp(input int a, output logic [39:0] p);
        logic [4:0]  rd;
        logic [31:0] d;
        logic        dw, er, got;
        rd = 5'($urandom);
        d  = $urandom;
        dw = 1'($urandom);
        er = 1'($urandom);
        p  = pk(a, rd, d, dw, er);
        exp_p.push_back(p);
        if (cnt_m[a] == 0) err_m = 1'b1;
        else cnt_m[a]--;
        acc_p_valid_i[a] = 1'b1;
        acc_p_rd_i[a*5 +: 5] = rd;
        acc_p_data_i[a*DW +: DW] = d;
        acc_p_dualwb_i[a] = dw;
        acc_p_error_i[a] = er;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            got = acc_p_ready_o[a];
            @(posedge clk); #1;
        end
        acc_p_valid_i[a] = 1'b0;
        if (!got) fail("resp_timeout", "got no acc_p_ready in 20 cycles, expected one");
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        chk("drain_k", 64'(exp_k.size()), 0);
        chk("drain_p", 64'(exp_p.size()), 0);
        rst_i = 1'b1;
        x_q_valid_i = 1'b1;
        acc_q_ready_i = '1;
        acc_k_accept_i = '1;
        acc_p_valid_i = '1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_q_valid", 64'(acc_q_valid_o), 0);
        chk("rst_q_ready", 64'(x_q_ready_o), 0);
        chk("rst_k", 64'({x_k_accept_o, x_k_is_mem_op_o, x_k_writeback_o}), 0);
        chk("rst_p_ready", 64'(acc_p_ready_o), 0);
        chk("rst_p_valid", 64'(x_p_valid_o), 0);
        chk("rst_errs", 64'({multi_accept_err_o, resp_err_o}), 0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        x_q_valid_i = 1'b0;
        acc_q_ready_i = '0;
        acc_k_accept_i = '0;
        acc_p_valid_i = '0;
        cnt_m = '{0, 0};
        multi_m = 1'b0;
        err_m = 1'b0;
    endtask

    initial begin
        x_q_valid_i = 0; x_q_instr_data_i = 0; x_q_rs_i = 0; x_q_rs_valid_i = 0; x_q_rd_clean_i = 0;
        x_p_ready_i = 1; acc_q_ready_i = 0; acc_k_accept_i = 0; acc_k_is_mem_op_i = 0; acc_k_writeback_i = 0;
        acc_p_valid_i = 0; acc_p_rd_i = 0; acc_p_data_i = 0; acc_p_dualwb_i = 0; acc_p_error_i = 0;
        do_reset();
        issue(0, 0, 2'b10, 2'b00, 2'b10, cyc, qv);
        chk("same_cycle_ready", 64'(cyc), 0);
        issue(0, 3, 2'b01, 2'b00, 2'b00, cyc, qv);
        chk("collect_ready_cycle", 64'(cyc), 3);
        chk("collect_q_valid_t1", 64'(qv), 2'b10);
        issue(0, 0, 2'b01, 2'b01, 2'b01, cyc, qv);
        issue(1, 0, 2'b01, 2'b00, 2'b01, cyc, qv);
        issue(0, 2, 2'b10, 2'b00, 2'b10, cyc, qv);
        x_q_valid_i = 1'b1;
        acc_q_ready_i = '0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_q_valid", 64'(acc_q_valid_o), (cnt_m[0] + cnt_m[1] >= MO) ? 0 : 3);
            chk("stall_q_ready", 64'(x_q_ready_o), 0);
            @(posedge clk); #1;
        end
        send_resp(1, pr);
        @(negedge clk);
        chk("resume_q_valid", 64'(acc_q_valid_o), (cnt_m[0] + cnt_m[1] >= MO) ? 0 : 3);
        @(posedge clk); #1;
        issue(0, 0, 2'b00, 2'b11, 2'b11, cyc, qv);
        x_p_ready_i = 1'b0;
        send_resp(0, d1);
        acc_p_valid_i[0] = 1'b1;
        acc_p_data_i[DW-1:0] = ~d1[33:2];
        repeat (3) begin
            @(negedge clk);
            chk("hold_valid", 64'(x_p_valid_o), 1);
            chk("hold_data", 64'(x_p_data_o), 64'(d1[33:2]));
            chk("hold_p_ready", 64'(acc_p_ready_o), 0);
            @(posedge clk); #1;
        end
        acc_p_valid_i = '0;
        x_p_ready_i = 1'b1;
        send_resp(0, pr);
        for (int n = 0; n < 40; n++) begin
            if (cnt_m[0] + cnt_m[1] >= MO || $urandom_range(0, 2) == 0) begin
                if (cnt_m[0] > 0 && (cnt_m[1] == 0 || $urandom_range(0, 1) == 0)) send_resp(0, pr);
                else if (cnt_m[1] > 0) send_resp(1, pr);
            end
            issue($urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom), 2'($urandom), 2'($urandom), cyc, qv);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("random_multi_flag", 64'(multi_accept_err_o), 64'(multi_m));
        chk("random_resp_err", 64'(resp_err_o), 64'(err_m));
        do_reset();
        issue(0, 0, 2'b11, 2'b10, 2'b01, cyc, qv);
        @(negedge clk);
        chk("multi_set", 64'(multi_accept_err_o), 64'(multi_m));
        repeat (3) @(posedge clk);
        #1;
        issue(0, 1, 2'b10, 2'b00, 2'b10, cyc, qv);
        @(negedge clk);
        chk("multi_sticky", 64'(multi_accept_err_o), 64'(multi_m));
        do_reset();
        send_resp(1, pr);
        @(negedge clk);
        chk("resp_err_after_reset", 64'(resp_err_o), 64'(err_m));
        do_reset();
        issue(0, 0, 2'b01, 2'b00, 2'b01, cyc, qv);
        issue(0, 0, 2'b01, 2'b00, 2'b01, cyc, qv);
        issue(0, 0, 2'b10, 2'b00, 2'b10, cyc, qv);
        issue(0, 0, 2'b10, 2'b00, 2'b10, cyc, qv);
        for (int j = 0; j < 2; j++)
            for (int i = 0; i < NA; i++) begin
                exp_p.push_back(pk(i, 5'(i * 8 + j), 32'hA500_0000 + 32'(i * 256 + j), 1'(j), 1'(i)));
                cnt_m[i]--;
            end
        ka = '{0, 0};
        c = 0;
        while ((ka[0] < 2 || ka[1] < 2) && c < 20) begin
            for (int i = 0; i < NA; i++) begin
                acc_p_valid_i[i] = ka[i] < 2;
                acc_p_rd_i[i*5 +: 5] = 5'(i * 8 + ka[i]);
                acc_p_data_i[i*DW +: DW] = 32'hA500_0000 + 32'(i * 256 + ka[i]);
                acc_p_dualwb_i[i] = 1'(ka[i]);
                acc_p_error_i[i] = 1'(i);
            end
            @(negedge clk);
            if (c == 0) chk("p_latency_c0", 64'(x_p_valid_o), 0);
            if (c == 1) chk("p_latency_c1", 64'(x_p_valid_o), 1);
            rdy = acc_p_ready_o & acc_p_valid_i;
            @(posedge clk); #1;
            for (int i = 0; i < NA; i++) if (rdy[i]) ka[i]++;
            c++;
        end
        acc_p_valid_i = '0;
        chk("p_throughput_cycles", 64'(c), 4);
        repeat (3) @(posedge clk);
        #1;
        chk("final_drain_k", 64'(exp_k.size()), 0);
        chk("final_drain_p", 64'(exp_p.size()), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/cv32e40p_x_if_dispatch.md
Name: cv32e40p_x_if_dispatch

Overview:
Parametrised X-interface fan-out between the core and NUM_ACC accelerators, generalising the single-accelerator wrapper.
- Broadcasts each offload request to all accelerators and collects per-accelerator handshakes.
- Returns one merged accept/is_mem_op/writeback decision to the core.
- Merges accelerator responses through a registered round-robin arbiter.
- Tracks outstanding writeback instructions to throttle issue.
- Memory channels are out of scope and stay point-to-point.

Parameters:
NUM_ACC, 2, number of accelerator ports (>=1)
NUM_RS, 3, source operands per request
DATA_WIDTH, 32, operand/result width
MAX_OUTSTANDING, 4, max in-flight accepted writeback instructions, all accelerators combined
ID_W, $clog2(NUM_ACC) (min 1), accelerator index width

Ports:
clk_i in 1 clock
rst_i in 1 synchronous active-high reset
x_q_valid_i in 1 core request valid
x_q_ready_o out 1 core request ready
x_q_instr_data_i in 32 instruction word
x_q_rs_i in NUM_RS*DATA_WIDTH operands
x_q_rs_valid_i in NUM_RS operand valids
x_q_rd_clean_i in 1 rd not pending
x_k_accept_o, x_k_is_mem_op_o, x_k_writeback_o out 1 each, merged decision, valid with request handshake
x_p_valid_o out 1; x_p_ready_i in 1; x_p_rd_o out 5; x_p_data_o out DATA_WIDTH; x_p_dualwb_o, x_p_error_o out 1 each; x_p_acc_id_o out ID_W (source accelerator)
acc_q_valid_o out NUM_ACC; acc_q_ready_i in NUM_ACC
acc_q_instr_data_o, acc_q_rs_o, acc_q_rs_valid_o, acc_q_rd_clean_o out, broadcast copies of core inputs
acc_k_accept_i, acc_k_is_mem_op_i, acc_k_writeback_i in NUM_ACC each
acc_p_valid_i in NUM_ACC; acc_p_ready_o out NUM_ACC; acc_p_rd_i in NUM_ACC*5; acc_p_data_i in NUM_ACC*DATA_WIDTH; acc_p_dualwb_i, acc_p_error_i in NUM_ACC each
multi_accept_err_o out 1 sticky: more than one accelerator accepted
resp_err_o out 1 sticky: response from accelerator with zero outstanding

Behaviour:
- Reset (rst_i high at clk_i edge): state IDLE, done mask 0, latched k-bits 0, all outstanding counters 0, RR pointer 0, response register empty, both err flags 0. Every output is 0 during and after reset except the broadcast data copies.
- Stall: stall = (total outstanding == MAX_OUTSTANDING). While stalled, acc_q_valid_o = 0 and x_q_ready_o = 0.
- Request FSM: IDLE, COLLECT.
  - acc_q_valid_o[i] = x_q_valid_i & ~stall_at_entry & ~done[i]. Stall is only sampled in IDLE.
  - Per-acc handshake when acc_q_valid_o[i] & acc_q_ready_i[i]: set done[i] and latch that accelerator's k-bits.
  - x_q_ready_o = 1 in the cycle where (done | current handshakes) becomes all ones. Same cycle, x_k_* = merge of latched and current bits.
  - Merge: accept = OR of all accepts. Winner = lowest-index accepting accelerator; is_mem_op and writeback come from the winner. No acceptor: all three 0.
  - Same-cycle full handshake from IDLE: ready in cycle 0, no COLLECT entry.
  - Otherwise IDLE -> COLLECT on the first partial handshake. COLLECT -> IDLE on core handshake, then clear mask.
  - Core keeps valid/data stable until ready, so the request is not re-registered.
- Multiple accepters in one request: set multi_accept_err_o (sticky until reset). Winner's bits are still used.
- Outstanding tracking:
  - Per-acc counter, width $clog2(MAX_OUTSTANDING+1).
  - +1 on core handshake with accept & writeback (winner's counter).
  - −1 on response handshake from that accelerator.
  - Simultaneous +1/−1 on the same counter: unchanged.
  - Response while the counter is 0: forward it, set resp_err_o, counter saturates at 0.
- Response path:
  - RR arbiter grants among acc_p_valid_i starting at the pointer.
  - acc_p_ready_o[g] = grant[g] & (reg empty | x_p_ready_i).
  - On grant handshake, load the output register (rd, data, dualwb, error, acc_id) and advance the pointer to g+1 mod NUM_ACC.
  - Latency: accelerator response to x_p_valid_o is 1 cycle. Full throughput when x_p_ready_i is held high.
  - x_p_valid_o holds with stable data until x_p_ready_i.
- Reset mid-operation: in-flight request and buffered response are dropped; counters cleared.

Decomposition:
- Package cv32e40p_x_if_pkg gains:
  - x_acc_resp_t: rd, data, dualwb, error.
  - x_dispatch_state_e: IDLE, COLLECT.
  - Function acc_id_width(n).
- One sub-module, cv32e40p_x_if_rr_arb (params N; inputs req, advance; output one-hot grant plus index). Reused for future memory-channel arbitration.

Test Plan:
- NUM_ACC=2, both ready cycle 0, acc1 accepts with wb=1 -> x_q_ready_o=1 at cycle 0, x_k_accept_o=1, x_k_writeback_o=1, acc1 counter=1.
- acc0 ready cycle 0, acc1 ready cycle 3, acc0 accepts -> acc_q_valid_o[0] low from cycle 1; x_q_ready_o only at cycle 3 with accept=1 from latched bit.
- 4 accepted writeback instructions, no responses -> 5th request: x_q_ready_o=0 and acc_q_valid_o=0. One response consumed -> issue resumes next cycle.
- Both accelerators respond every cycle, x_p_ready_i=1 -> x_p_acc_id_o alternates 0,1,0,1; x_p_valid_o first rises 1 cycle after the responses.
- x_p_ready_i=0 for 3 cycles with a response registered -> x_p_data_o stable; acc_p_ready_o=00 for those cycles.
- Both accelerators accept one request -> multi_accept_err_o=1 and stays 1; winner id 0. rst_i pulse -> flag 0, counters 0.
